// File: rtl/dp_aux_arbiter.sv
// dp_aux_arbiter: shares one DisplayPort AUX request channel between the Link
// Policy Maker (native AUX) and the Stream Policy Maker (I2C-over-AUX). It grants
// one requester at a time, issues the latched header, routes replies back to the
// owner only, and reissues on DEFER replies and reply timeouts by itself.
module dp_aux_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 400,
  parameter int unsigned MAX_RETRY   = 7,
  parameter int unsigned DEFER_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // Link Policy Maker request side
  input  logic        LPM_Transaction_VLD,
  input  logic [3:0]  LPM_CMD,
  input  logic [19:0] LPM_Address,
  input  logic [7:0]  LPM_LEN,
  // Stream Policy Maker request side
  input  logic        SPM_Transaction_VLD,
  input  logic [3:0]  SPM_CMD,
  input  logic [19:0] SPM_Address,
  input  logic [7:0]  SPM_LEN,
  // Requester status and reply
  output logic        LPM_Grant,
  output logic        SPM_Grant,
  output logic        LPM_Native_I2C,
  output logic        SPM_Native_I2C,
  output logic [1:0]  LPM_Reply_ACK,
  output logic        LPM_Reply_ACK_VLD,
  output logic [7:0]  LPM_Reply_Data,
  output logic        LPM_Reply_Data_VLD,
  output logic [1:0]  SPM_Reply_ACK,
  output logic        SPM_Reply_ACK_VLD,
  output logic [7:0]  SPM_Reply_Data,
  output logic        SPM_Reply_Data_VLD,
  output logic        LPM_Timeout,
  output logic        SPM_Timeout,
  // Link layer request channel
  output logic        AUX_Req_VLD,
  input  logic        AUX_Req_RDY,
  output logic [3:0]  AUX_CMD,
  output logic [19:0] AUX_Address,
  output logic [7:0]  AUX_LEN,
  output logic        AUX_Owner,
  // Link layer reply channel
  input  logic        AUX_Reply_ACK_VLD,
  input  logic [3:0]  AUX_Reply_ACK,
  input  logic        AUX_Reply_Data_VLD,
  input  logic [7:0]  AUX_Reply_Data,
  input  logic        AUX_Reply_Done,
  output logic        AUX_Protocol_Err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam int unsigned GW = $clog2(DEFER_GAP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REPLY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [7:0]  len;
  } aux_hdr_t;

  state_e        state_q, state_d;
  aux_hdr_t      hdr_q, hdr_d;
  logic          owner_q, owner_d;       // 0 = LPM, 1 = SPM
  logic          rr_q, rr_d;             // requester favoured on a tie
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          retry_flag_q, retry_flag_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          lpm_grant_q, lpm_grant_d;
  logic          spm_grant_q, spm_grant_d;
  logic          lpm_native_q, lpm_native_d;
  logic          spm_native_q, spm_native_d;
  logic [1:0]    lpm_ack_q, lpm_ack_d;
  logic          lpm_ack_vld_q, lpm_ack_vld_d;
  logic [7:0]    lpm_data_q, lpm_data_d;
  logic          lpm_data_vld_q, lpm_data_vld_d;
  logic [1:0]    spm_ack_q, spm_ack_d;
  logic          spm_ack_vld_q, spm_ack_vld_d;
  logic [7:0]    spm_data_q, spm_data_d;
  logic          spm_data_vld_q, spm_data_vld_d;
  logic          lpm_to_q, lpm_to_d;
  logic          spm_to_q, spm_to_d;
  logic          req_vld_q, req_vld_d;
  logic          perr_q, perr_d;

  logic reply_any;
  logic is_defer;
  logic can_retry;
  logic suppress;
  logic fwd_ack;
  logic fwd_data;
  logic to_pulse;
  logic win;

  // Reply classification against the current owner and retry budget
  always_comb begin
    reply_any = AUX_Reply_ACK_VLD | AUX_Reply_Data_VLD | AUX_Reply_Done;
    if (owner_q) begin
      is_defer = (AUX_Reply_ACK[3:2] == 2'b10) || (AUX_Reply_ACK[1:0] == 2'b10);
    end else begin
      is_defer = (AUX_Reply_ACK[1:0] == 2'b10);
    end
    can_retry = (retry_cnt_q < RW'(MAX_RETRY));
    suppress  = is_defer && can_retry;
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_d        = state_q;
    hdr_d          = hdr_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    retry_cnt_d    = retry_cnt_q;
    retry_flag_d   = retry_flag_q;
    timer_d        = timer_q;
    gap_d          = gap_q;
    lpm_grant_d    = 1'b0;
    spm_grant_d    = 1'b0;
    lpm_ack_d      = lpm_ack_q;
    lpm_ack_vld_d  = 1'b0;
    lpm_data_d     = lpm_data_q;
    lpm_data_vld_d = 1'b0;
    spm_ack_d      = spm_ack_q;
    spm_ack_vld_d  = 1'b0;
    spm_data_d     = spm_data_q;
    spm_data_vld_d = 1'b0;
    lpm_to_d       = 1'b0;
    spm_to_d       = 1'b0;
    perr_d         = 1'b0;
    fwd_ack        = 1'b0;
    fwd_data       = 1'b0;
    to_pulse       = 1'b0;
    win            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        perr_d = reply_any;
        if (LPM_Transaction_VLD || SPM_Transaction_VLD) begin
          win          = (LPM_Transaction_VLD && SPM_Transaction_VLD) ? rr_q : SPM_Transaction_VLD;
          owner_d      = win;
          hdr_d        = win ? '{cmd: SPM_CMD, addr: SPM_Address, len: SPM_LEN}
                             : '{cmd: LPM_CMD, addr: LPM_Address, len: LPM_LEN};
          lpm_grant_d  = !win;
          spm_grant_d  = win;
          rr_d         = !win;
          retry_cnt_d  = '0;
          retry_flag_d = 1'b0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        perr_d = reply_any;
        if (AUX_Req_RDY) begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (AUX_Reply_ACK_VLD) begin
          if (suppress) begin
            retry_cnt_d  = retry_cnt_q + RW'(1);
            retry_flag_d = 1'b1;
          end else begin
            fwd_ack = 1'b1;
          end
          fwd_data = AUX_Reply_Data_VLD && !suppress;
          if (AUX_Reply_Done) begin
            gap_d   = '0;
            state_d = suppress ? ST_GAP : ST_IDLE;
          end else begin
            state_d = ST_REPLY;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          if (can_retry) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            gap_d       = '0;
            state_d     = ST_GAP;
          end else begin
            to_pulse = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_REPLY: begin
        fwd_data = AUX_Reply_Data_VLD && !retry_flag_q;
        if (AUX_Reply_Done) begin
          gap_d   = '0;
          state_d = retry_flag_q ? ST_GAP : ST_IDLE;
        end
      end

      ST_GAP: begin
        perr_d = reply_any;
        if (gap_q == GW'(DEFER_GAP - 1)) begin
          retry_flag_d = 1'b0;
          state_d      = ST_ISSUE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Route forwarded reply fields and timeout to the owner only
    if (fwd_ack) begin
      if (owner_q) begin
        spm_ack_vld_d = 1'b1;
        spm_ack_d     = AUX_Reply_ACK[3:2];
      end else begin
        lpm_ack_vld_d = 1'b1;
        lpm_ack_d     = AUX_Reply_ACK[1:0];
      end
    end
    if (fwd_data) begin
      if (owner_q) begin
        spm_data_vld_d = 1'b1;
        spm_data_d     = AUX_Reply_Data;
      end else begin
        lpm_data_vld_d = 1'b1;
        lpm_data_d     = AUX_Reply_Data;
      end
    end
    lpm_to_d = to_pulse && !owner_q;
    spm_to_d = to_pulse && owner_q;

    req_vld_d    = (state_d == ST_ISSUE);
    lpm_native_d = (state_d != ST_IDLE) && !owner_d;
    spm_native_d = (state_d != ST_IDLE) && owner_d;
  end

  // State and output registers; reset abandons any transaction silently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      hdr_q          <= '0;
      owner_q        <= 1'b0;
      rr_q           <= 1'b0;
      retry_cnt_q    <= '0;
      retry_flag_q   <= 1'b0;
      timer_q        <= '0;
      gap_q          <= '0;
      lpm_grant_q    <= 1'b0;
      spm_grant_q    <= 1'b0;
      lpm_native_q   <= 1'b0;
      spm_native_q   <= 1'b0;
      lpm_ack_q      <= '0;
      lpm_ack_vld_q  <= 1'b0;
      lpm_data_q     <= '0;
      lpm_data_vld_q <= 1'b0;
      spm_ack_q      <= '0;
      spm_ack_vld_q  <= 1'b0;
      spm_data_q     <= '0;
      spm_data_vld_q <= 1'b0;
      lpm_to_q       <= 1'b0;
      spm_to_q       <= 1'b0;
      req_vld_q      <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_q          <= hdr_d;
      owner_q        <= owner_d;
      rr_q           <= rr_d;
      retry_cnt_q    <= retry_cnt_d;
      retry_flag_q   <= retry_flag_d;
      timer_q        <= timer_d;
      gap_q          <= gap_d;
      lpm_grant_q    <= lpm_grant_d;
      spm_grant_q    <= spm_grant_d;
      lpm_native_q   <= lpm_native_d;
      spm_native_q   <= spm_native_d;
      lpm_ack_q      <= lpm_ack_d;
      lpm_ack_vld_q  <= lpm_ack_vld_d;
      lpm_data_q     <= lpm_data_d;
      lpm_data_vld_q <= lpm_data_vld_d;
      spm_ack_q      <= spm_ack_d;
      spm_ack_vld_q  <= spm_ack_vld_d;
      spm_data_q     <= spm_data_d;
      spm_data_vld_q <= spm_data_vld_d;
      lpm_to_q       <= lpm_to_d;
      spm_to_q       <= spm_to_d;
      req_vld_q      <= req_vld_d;
      perr_q         <= perr_d;
    end
  end

  assign LPM_Grant          = lpm_grant_q;
  assign SPM_Grant          = spm_grant_q;
  assign LPM_Native_I2C     = lpm_native_q;
  assign SPM_Native_I2C     = spm_native_q;
  assign LPM_Reply_ACK      = lpm_ack_q;
  assign LPM_Reply_ACK_VLD  = lpm_ack_vld_q;
  assign LPM_Reply_Data     = lpm_data_q;
  assign LPM_Reply_Data_VLD = lpm_data_vld_q;
  assign SPM_Reply_ACK      = spm_ack_q;
  assign SPM_Reply_ACK_VLD  = spm_ack_vld_q;
  assign SPM_Reply_Data     = spm_data_q;
  assign SPM_Reply_Data_VLD = spm_data_vld_q;
  assign LPM_Timeout        = lpm_to_q;
  assign SPM_Timeout        = spm_to_q;
  assign AUX_Req_VLD        = req_vld_q;
  assign AUX_CMD            = hdr_q.cmd;
  assign AUX_Address        = hdr_q.addr;
  assign AUX_LEN            = hdr_q.len;
  assign AUX_Owner          = owner_q;
  assign AUX_Protocol_Err   = perr_q;

endmodule

// File: tb/tb_dp_aux_arbiter.sv
// Directed bench for dp_aux_arbiter: inputs are driven and outputs sampled on
// the falling edge; event counters sample outputs on the rising edge.
module tb_dp_aux_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        LPM_Transaction_VLD, SPM_Transaction_VLD;
  logic [3:0]  LPM_CMD, SPM_CMD;
  logic [19:0] LPM_Address, SPM_Address;
  logic [7:0]  LPM_LEN, SPM_LEN;
  logic        LPM_Grant, SPM_Grant, LPM_Native_I2C, SPM_Native_I2C;
  logic [1:0]  LPM_Reply_ACK, SPM_Reply_ACK;
  logic        LPM_Reply_ACK_VLD, SPM_Reply_ACK_VLD;
  logic [7:0]  LPM_Reply_Data, SPM_Reply_Data;
  logic        LPM_Reply_Data_VLD, SPM_Reply_Data_VLD;
  logic        LPM_Timeout, SPM_Timeout;
  logic        AUX_Req_VLD, AUX_Req_RDY;
  logic [3:0]  AUX_CMD;
  logic [19:0] AUX_Address;
  logic [7:0]  AUX_LEN;
  logic        AUX_Owner;
  logic        AUX_Reply_ACK_VLD;
  logic [3:0]  AUX_Reply_ACK;
  logic        AUX_Reply_Data_VLD;
  logic [7:0]  AUX_Reply_Data;
  logic        AUX_Reply_Done;
  logic        AUX_Protocol_Err;

  always #5 clk = ~clk;

  dp_aux_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .LPM_Transaction_VLD(LPM_Transaction_VLD), .LPM_CMD(LPM_CMD),
    .LPM_Address(LPM_Address), .LPM_LEN(LPM_LEN),
    .SPM_Transaction_VLD(SPM_Transaction_VLD), .SPM_CMD(SPM_CMD),
    .SPM_Address(SPM_Address), .SPM_LEN(SPM_LEN),
    .LPM_Grant(LPM_Grant), .SPM_Grant(SPM_Grant),
    .LPM_Native_I2C(LPM_Native_I2C), .SPM_Native_I2C(SPM_Native_I2C),
    .LPM_Reply_ACK(LPM_Reply_ACK), .LPM_Reply_ACK_VLD(LPM_Reply_ACK_VLD),
    .LPM_Reply_Data(LPM_Reply_Data), .LPM_Reply_Data_VLD(LPM_Reply_Data_VLD),
    .SPM_Reply_ACK(SPM_Reply_ACK), .SPM_Reply_ACK_VLD(SPM_Reply_ACK_VLD),
    .SPM_Reply_Data(SPM_Reply_Data), .SPM_Reply_Data_VLD(SPM_Reply_Data_VLD),
    .LPM_Timeout(LPM_Timeout), .SPM_Timeout(SPM_Timeout),
    .AUX_Req_VLD(AUX_Req_VLD), .AUX_Req_RDY(AUX_Req_RDY),
    .AUX_CMD(AUX_CMD), .AUX_Address(AUX_Address), .AUX_LEN(AUX_LEN),
    .AUX_Owner(AUX_Owner),
    .AUX_Reply_ACK_VLD(AUX_Reply_ACK_VLD), .AUX_Reply_ACK(AUX_Reply_ACK),
    .AUX_Reply_Data_VLD(AUX_Reply_Data_VLD), .AUX_Reply_Data(AUX_Reply_Data),
    .AUX_Reply_Done(AUX_Reply_Done), .AUX_Protocol_Err(AUX_Protocol_Err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Event counters and exclusivity/isolation monitors
  int   lpm_grants = 0, spm_grants = 0, issues = 0;
  int   lpm_acks = 0, spm_acks = 0, lpm_datas = 0, spm_datas = 0;
  int   lpm_tos = 0, spm_tos = 0, excl_err = 0, iso_err = 0;
  logic req_prev = 1'b0;

  always @(posedge clk) begin
    if (LPM_Grant) lpm_grants <= lpm_grants + 1;
    if (SPM_Grant) spm_grants <= spm_grants + 1;
    if (AUX_Req_VLD && !req_prev) issues <= issues + 1;
    req_prev <= AUX_Req_VLD;
    if (LPM_Reply_ACK_VLD) lpm_acks <= lpm_acks + 1;
    if (SPM_Reply_ACK_VLD) spm_acks <= spm_acks + 1;
    if (LPM_Reply_Data_VLD) lpm_datas <= lpm_datas + 1;
    if (SPM_Reply_Data_VLD) spm_datas <= spm_datas + 1;
    if (LPM_Timeout) lpm_tos <= lpm_tos + 1;
    if (SPM_Timeout) spm_tos <= spm_tos + 1;
    if (LPM_Native_I2C && SPM_Native_I2C) excl_err <= excl_err + 1;
    if ((!AUX_Owner && (SPM_Reply_ACK_VLD || SPM_Reply_Data_VLD || SPM_Timeout)) ||
        ( AUX_Owner && (LPM_Reply_ACK_VLD || LPM_Reply_Data_VLD || LPM_Timeout)))
      iso_err <= iso_err + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    LPM_Transaction_VLD = 0; SPM_Transaction_VLD = 0;
    LPM_CMD = 4'h9; LPM_Address = 20'h00100; LPM_LEN = 8'h00;
    SPM_CMD = 4'h1; SPM_Address = 20'h00050; SPM_LEN = 8'h00;
    AUX_Req_RDY = 1; AUX_Reply_ACK_VLD = 0; AUX_Reply_ACK = 0;
    AUX_Reply_Data_VLD = 0; AUX_Reply_Data = 0; AUX_Reply_Done = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    cyc(3);
    reset_n = 1;
    cyc(1);
  endtask

  // Simultaneous request round; winner completes with ACK and Done together
  task automatic rr_round(input bit exp_spm, input logic [3:0] ack, input logic [1:0] exp_ack,
                          input string tag);
    LPM_Transaction_VLD = 1; SPM_Transaction_VLD = 1;
    cyc();
    check({tag, "_grant"}, {LPM_Grant, SPM_Grant}, exp_spm ? 2'b01 : 2'b10);
    check({tag, "_cmd"}, AUX_CMD, exp_spm ? 4'h1 : 4'h9);
    LPM_Transaction_VLD = 0; SPM_Transaction_VLD = 0;
    cyc();
    AUX_Reply_ACK_VLD = 1; AUX_Reply_ACK = ack; AUX_Reply_Done = 1;
    cyc();
    AUX_Reply_ACK_VLD = 0; AUX_Reply_Done = 0;
    check({tag, "_ack"}, exp_spm ? {SPM_Reply_ACK_VLD, SPM_Reply_ACK}
                                 : {LPM_Reply_ACK_VLD, LPM_Reply_ACK}, {1'b1, exp_ack});
    check({tag, "_idle"}, {LPM_Native_I2C, SPM_Native_I2C}, 2'b00);
    cyc();
  endtask

  int k, s0, s1, s2, s3, s4;

  initial begin
    reset_n = 0;
    clear_inputs();

    // Reset state
    do_reset();
    check("rst_ctrl", {LPM_Grant, SPM_Grant, LPM_Native_I2C, SPM_Native_I2C, AUX_Req_VLD,
                       AUX_Owner, AUX_Protocol_Err, LPM_Timeout, SPM_Timeout}, 0);
    check("rst_hdr", {AUX_CMD, AUX_Address, AUX_LEN}, 0);

    // LPM-only native read with one data byte
    LPM_Transaction_VLD = 1;
    cyc();
    check("t1_grant", LPM_Grant, 1);
    check("t1_req", AUX_Req_VLD, 1);
    check("t1_hdr", {AUX_CMD, AUX_Address, AUX_LEN}, {4'h9, 20'h00100, 8'h00});
    check("t1_native", {LPM_Native_I2C, SPM_Native_I2C, AUX_Owner}, 3'b100);
    LPM_Transaction_VLD = 0;
    cyc();
    check("t1_pulse", {LPM_Grant, AUX_Req_VLD}, 2'b00);
    AUX_Reply_ACK_VLD = 1; AUX_Reply_ACK = 4'h0;
    cyc();
    AUX_Reply_ACK_VLD = 0;
    check("t1_ack", {LPM_Reply_ACK_VLD, LPM_Reply_ACK}, 3'b100);
    AUX_Reply_Data_VLD = 1; AUX_Reply_Data = 8'hA5;
    cyc();
    AUX_Reply_Data_VLD = 0;
    check("t1_data", {LPM_Reply_ACK_VLD, LPM_Reply_Data_VLD, LPM_Reply_Data}, {2'b01, 8'hA5});
    AUX_Reply_Done = 1;
    cyc();
    AUX_Reply_Done = 0;
    check("t1_done", LPM_Native_I2C, 0);
    cyc();
    check("t1_spm_quiet", spm_grants + spm_acks + spm_datas + spm_tos, 0);
    check("t1_lpm_cnt", {8'(lpm_acks), 8'(lpm_datas)}, 16'h0101);

    // Round robin from reset: LPM, SPM, LPM
    do_reset();
    s0 = lpm_grants; s1 = spm_grants;
    rr_round(1'b0, 4'h8, 2'b00, "rr1");
    rr_round(1'b1, 4'h4, 2'b01, "rr2");
    rr_round(1'b0, 4'h9, 2'b01, "rr3");
    check("rr_counts", {8'(lpm_grants - s0), 8'(spm_grants - s1)}, 16'h0201);

    // SPM I2C read, three I2C DEFERs then ACK
    s0 = issues; s1 = spm_acks; s2 = spm_datas; s3 = spm_grants;
    SPM_Transaction_VLD = 1;
    cyc();
    check("t3_grant", SPM_Grant, 1);
    SPM_Transaction_VLD = 0;
    for (int r = 0; r < 4; r++) begin
      check("t3_issue", {AUX_Req_VLD, AUX_CMD, AUX_Owner}, {1'b1, 4'h1, 1'b1});
      cyc();
      AUX_Reply_ACK_VLD = 1; AUX_Reply_ACK = (r < 3) ? 4'h8 : 4'h0;
      cyc();
      AUX_Reply_ACK_VLD = 0;
      check("t3_ackvld", SPM_Reply_ACK_VLD, (r == 3) ? 1 : 0);
      AUX_Reply_Data_VLD = 1; AUX_Reply_Data = (r < 3) ? 8'h33 : 8'h5A;
      cyc();
      AUX_Reply_Data_VLD = 0;
      check("t3_datavld", SPM_Reply_Data_VLD, (r == 3) ? 1 : 0);
      AUX_Reply_Done = 1;
      if (r < 3) begin
        k = 0;
        do begin
          cyc();
          k++;
          if (k == 1) AUX_Reply_Done = 0;
        end while (!AUX_Req_VLD && k < 100);
        check("t3_gap", k, 17);
      end else begin
        cyc();
        AUX_Reply_Done = 0;
      end
    end
    cyc(2);
    check("t3_issues", issues - s0, 4);
    check("t3_fwd", {8'(spm_acks - s1), 8'(spm_datas - s2), 8'(spm_grants - s3)}, 24'h010101);
    check("t3_final", {SPM_Reply_ACK, SPM_Reply_Data}, {2'b00, 8'h5A});

    // No reply at all: eight issues, then LPM timeout
    s4 = lpm_tos;
    LPM_Transaction_VLD = 1;
    cyc();
    check("t4_grant", LPM_Grant, 1);
    LPM_Transaction_VLD = 0;
    s0 = issues;
    k = 0;
    while (!LPM_Timeout && k < 5000) begin
      cyc();
      k++;
    end
    check("t4_to_time", k, 3320);
    cyc();
    check("t4_to_pulse", {LPM_Timeout, LPM_Native_I2C}, 2'b00);
    cyc();
    check("t4_issues", issues - s0, 8);
    check("t4_to_cnt", lpm_tos - s4, 1);

    // Reset during WAIT; pointer currently favours SPM
    LPM_Transaction_VLD = 1;
    cyc();
    LPM_Transaction_VLD = 0;
    cyc(3);
    check("t5_pre", LPM_Native_I2C, 1);
    s4 = lpm_tos;
    reset_n = 0;
    #1;
    check("t5_rst_ctrl", {LPM_Native_I2C, AUX_Req_VLD, AUX_Owner, LPM_Timeout}, 0);
    check("t5_rst_hdr", {AUX_CMD, AUX_Address}, 0);
    cyc(2);
    reset_n = 1;
    cyc();
    LPM_Transaction_VLD = 1; SPM_Transaction_VLD = 1;
    cyc();
    check("t5_grant", {LPM_Grant, SPM_Grant}, 2'b10);
    LPM_Transaction_VLD = 0; SPM_Transaction_VLD = 0;
    cyc();
    AUX_Reply_ACK_VLD = 1; AUX_Reply_ACK = 4'h0; AUX_Reply_Done = 1;
    cyc();
    AUX_Reply_ACK_VLD = 0; AUX_Reply_Done = 0;
    cyc(2);
    check("t5_no_to", lpm_tos - s4, 0);

    // Reply inputs in IDLE are protocol errors and go nowhere
    s0 = lpm_acks; s1 = spm_acks;
    AUX_Reply_ACK_VLD = 1; AUX_Reply_ACK = 4'h0;
    cyc();
    AUX_Reply_ACK_VLD = 0;
    check("t6_err", AUX_Protocol_Err, 1);
    check("t6_no_ack", {LPM_Reply_ACK_VLD, SPM_Reply_ACK_VLD}, 2'b00);
    cyc();
    check("t6_err_pulse", AUX_Protocol_Err, 0);
    AUX_Reply_Data_VLD = 1;
    cyc();
    AUX_Reply_Data_VLD = 0;
    check("t6_err_data", {AUX_Protocol_Err, LPM_Reply_Data_VLD, SPM_Reply_Data_VLD}, 3'b100);
    cyc(2);
    check("t6_ack_cnt", {8'(lpm_acks - s0), 8'(spm_acks - s1)}, 16'h0000);

    check("native_excl", excl_err, 0);
    check("owner_iso", iso_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
